// File: rtl/filtro_iir_mac_pkg.sv
// -----------------------------------------------------------------------------
// filtro_iir_mac_pkg
// Shared definitions for the biquad IIR filter and its coefficient mux:
//   - default word width / fractional bits
//   - FSM state encoding
//   - coefficient selector codes and the step -> selector mapping
//   - the team coefficient mux (a function, so the filter's environment and
//     any bench use the same table)
// -----------------------------------------------------------------------------
package filtro_iir_mac_pkg;

  localparam int ANCHO_DEF = 25;
  localparam int FRAC_DEF  = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_SAT  = 3'd3,
    ST_DONE = 3'd4
  } estado_t;

  // Coefficient selector codes.
  localparam logic [2:0] SEL_A0 = 3'b000;
  localparam logic [2:0] SEL_A1 = 3'b001;
  localparam logic [2:0] SEL_A2 = 3'b010;
  localparam logic [2:0] SEL_B0 = 3'b011;
  localparam logic [2:0] SEL_B1 = 3'b100;
  localparam logic [2:0] SEL_B2 = 3'b101;

  // Team coefficients, Q12.13 (1.0 = 0x2000).
  localparam logic [ANCHO_DEF-1:0] COEF_A0 = 25'h0002000;  //  1.0
  localparam logic [ANCHO_DEF-1:0] COEF_A1 = 25'h1FFC000;  // -2.0
  localparam logic [ANCHO_DEF-1:0] COEF_A2 = 25'd8000;     // ~0.977
  localparam logic [ANCHO_DEF-1:0] COEF_B0 = 25'd3;
  localparam logic [ANCHO_DEF-1:0] COEF_B1 = 25'd12;
  localparam logic [ANCHO_DEF-1:0] COEF_B2 = 25'd3;

  // MAC step k -> coefficient selector (b0,b1,b2,a1,a2).
  function automatic logic [2:0] sel_de_paso(input logic [2:0] paso);
    logic [2:0] sel;
    case (paso)
      3'd0:    sel = SEL_B0;
      3'd1:    sel = SEL_B1;
      3'd2:    sel = SEL_B2;
      3'd3:    sel = SEL_A1;
      3'd4:    sel = SEL_A2;
      default: sel = SEL_A0;
    endcase
    return sel;
  endfunction

  // Team coefficient mux: purely combinational lookup on the selector.
  function automatic logic [ANCHO_DEF-1:0] coef_mux(input logic [2:0] sel);
    logic [ANCHO_DEF-1:0] c;
    case (sel)
      SEL_B0:  c = COEF_B0;
      SEL_B1:  c = COEF_B1;
      SEL_B2:  c = COEF_B2;
      SEL_A1:  c = COEF_A1;
      SEL_A2:  c = COEF_A2;
      default: c = COEF_A0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/filtro_iir_mac_mac_sat.sv
// -----------------------------------------------------------------------------
// filtro_mac_sat
// Signed multiply-accumulate with synchronous clear and add/subtract control,
// followed by a combinational arithmetic shift and saturation back to ANCHO.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear accumulator (takes priority over i_en)
//   i_en           : accumulate i_coef * i_dato this edge
//   i_resta        : 1 = subtract the product, 0 = add it
//   i_coef, i_dato : signed ANCHO-bit operands
//   o_sat          : (acc >>> FRAC) saturated to the ANCHO-bit signed range
// -----------------------------------------------------------------------------
module filtro_mac_sat
  import filtro_iir_mac_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_resta,
  input  logic signed [ANCHO-1:0] i_coef,
  input  logic signed [ANCHO-1:0] i_dato,
  output logic        [ANCHO-1:0] o_sat
);

  // Three guard bits: five full-width products can never overflow.
  localparam int ACC_W = 2*ANCHO + 3;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-ANCHO+1){1'b0}}, {(ANCHO-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-ANCHO+1){1'b1}}, {(ANCHO-1){1'b0}}};

  logic signed [2*ANCHO-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_shift;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_prod     = i_coef * i_dato;
  assign w_prod_ext = {{3{w_prod[2*ANCHO-1]}}, w_prod};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_resta ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

  // Arithmetic shift truncates toward -inf; then clamp to the output range.
  assign w_shift = r_acc >>> FRAC;

  always_comb begin
    o_sat = w_shift[ANCHO-1:0];
    if (w_shift > SAT_MAX) begin
      o_sat = SAT_MAX[ANCHO-1:0];
    end else if (w_shift < SAT_MIN) begin
      o_sat = SAT_MIN[ANCHO-1:0];
    end
  end

endmodule

// File: rtl/filtro_iir_mac.sv
// -----------------------------------------------------------------------------
// filtro_iir_mac
// Direct-form-I biquad, one shared multiplier, 9 cycles per sample:
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   inicio        : new-sample strobe, only looked at in IDLE
//   muestra_in    : x[n]
//   Constantes    : coefficient from the external mux for `selector`
//   selector      : coefficient index to the external mux (registered)
//   muestra_out   : y[n], held until the next result
//   listo         : one-cycle pulse, muestra_out just updated
//   ocupado       : high in every state except IDLE
//   o_estado      : current FSM state (debug)
// Handshake: a sample is accepted on the rising edge where inicio=1 and the
// FSM is in IDLE (ocupado=0); inicio at any other time is dropped. The result
// is announced by listo one cycle, 7 edges after acceptance.
// -----------------------------------------------------------------------------
module filtro_iir_mac
  import filtro_iir_mac_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] muestra_in,
  input  logic [ANCHO-1:0] Constantes,
  output logic [2:0]       selector,
  output logic [ANCHO-1:0] muestra_out,
  output logic             listo,
  output logic             ocupado,
  output logic [2:0]       o_estado
);

  estado_t          r_estado;
  logic [2:0]       r_paso;
  logic [2:0]       r_selector;
  logic             r_listo;
  logic             r_ocupado;
  logic [ANCHO-1:0] r_muestra_out;
  logic [ANCHO-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;

  logic             w_clr;
  logic             w_en;
  logic             w_resta;
  logic [ANCHO-1:0] w_dato;
  logic [ANCHO-1:0] w_sat;

  // Operand order matches the selector order b0,b1,b2,a1,a2.
  always_comb begin
    w_dato = r_y2;
    case (r_paso)
      3'd0:    w_dato = r_x0;
      3'd1:    w_dato = r_x1;
      3'd2:    w_dato = r_x2;
      3'd3:    w_dato = r_y1;
      default: w_dato = r_y2;
    endcase
  end

  assign w_clr   = (r_estado == ST_LOAD);
  assign w_en    = (r_estado == ST_MAC);
  assign w_resta = (r_paso >= 3'd3);  // feedback terms are subtracted

  filtro_mac_sat #(
    .ANCHO (ANCHO),
    .FRAC  (FRAC)
  ) u_mac_sat (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_resta (w_resta),
    .i_coef  (Constantes),
    .i_dato  (w_dato),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado      <= ST_IDLE;
      r_paso        <= 3'd0;
      r_selector    <= SEL_A0;
      r_listo       <= 1'b0;
      r_ocupado     <= 1'b0;
      r_muestra_out <= '0;
      r_x0          <= '0;
      r_x1          <= '0;
      r_x2          <= '0;
      r_y1          <= '0;
      r_y2          <= '0;
    end else begin
      r_listo <= 1'b0;
      case (r_estado)
        ST_IDLE: begin
          if (inicio) begin
            r_estado  <= ST_LOAD;
            r_ocupado <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_x0       <= muestra_in;
          r_paso     <= 3'd0;
          r_selector <= sel_de_paso(3'd0);
          r_estado   <= ST_MAC;
        end
        ST_MAC: begin
          if (r_paso == 3'd4) begin
            r_paso     <= 3'd0;
            r_selector <= SEL_A0;
            r_estado   <= ST_SAT;
          end else begin
            r_paso     <= r_paso + 3'd1;
            r_selector <= sel_de_paso(r_paso + 3'd1);
          end
        end
        ST_SAT: begin
          r_muestra_out <= w_sat;
          r_x2          <= r_x1;
          r_x1          <= r_x0;
          r_y2          <= r_y1;
          r_y1          <= w_sat;
          r_listo       <= 1'b1;
          r_estado      <= ST_DONE;
        end
        ST_DONE: begin
          r_ocupado <= 1'b0;
          r_estado  <= ST_IDLE;
        end
        default: begin
          r_ocupado <= 1'b0;
          r_estado  <= ST_IDLE;
        end
      endcase
    end
  end

  assign selector    = r_selector;
  assign muestra_out = r_muestra_out;
  assign listo       = r_listo;
  assign ocupado     = r_ocupado;
  assign o_estado    = r_estado;

endmodule

// File: doc/filtro_iir_mac.md
FILTRO_IIR_MAC -- requirements
Module: filtro_iir_mac

Interface
REQ-001 SHALL have parameter ANCHO, default 25, data/coefficient width in bits, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 13, fractional bits of every data and coefficient word.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inicio  input  1  new-sample strobe; sampled only in state IDLE.
REQ-006 SHALL have port muestra_in  input  ANCHO  input sample x[n].
REQ-007 SHALL have port Constantes  input  ANCHO  coefficient returned combinationally by the coefficient mux for the current selector.
REQ-008 SHALL have port selector  output  3  coefficient index driven to the coefficient mux.
REQ-009 SHALL have port muestra_out  output  ANCHO  filtered sample y[n], held until the next result.
REQ-010 SHALL have port listo  output  1  one-cycle pulse: muestra_out just updated.
REQ-011 SHALL have port ocupado  output  1  high in every state except IDLE.

Function
REQ-012 SHALL compute y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], in Q(ANCHO-FRAC).FRAC.
REQ-013 SHALL use selector codes: b0=3'b011, b1=3'b100, b2=3'b101, a1=3'b001, a2=3'b010; 3'b000 (a0) driven in IDLE, LOAD, SAT, DONE.
REQ-014 SHALL implement FSM IDLE -> LOAD -> MAC (5 cycles) -> SAT -> DONE -> IDLE.
REQ-015 SHALL leave IDLE only when inicio=1 at a rising edge; inicio in any other state is ignored, not queued.
REQ-016 SHALL in LOAD latch muestra_in into x0 and clear the accumulator.
REQ-017 SHALL in MAC step k=0..4 drive selector b0,b1,b2,a1,a2 in that order and at the step's closing edge add (k<3) or subtract (k>=3) Constantes times operand x0,x1,x2,y1,y2 respectively.
REQ-018 SHALL form each product at full 2*ANCHO signed width and accumulate at 2*ANCHO+3 bits; no intermediate rounding or overflow.
REQ-019 SHALL in SAT take accumulator >>> FRAC (arithmetic, truncation toward -inf) and saturate to [25'h1000000, 25'h0FFFFFF] for ANCHO=25.
REQ-020 SHALL at SAT's closing edge register muestra_out and shift delay line: x2<=x1, x1<=x0, y2<=y1, y1<=saturated result.
REQ-021 SHALL assert listo for exactly the DONE cycle, i.e. visible after the 7th rising edge following the edge that sampled inicio; next inicio accepted from the edge that returns to IDLE.
REQ-022 SHALL keep muestra_out and the delay line unchanged outside SAT.

Reset
REQ-023 SHALL on reset_n=0 immediately force state IDLE, selector=3'b000, listo=0, ocupado=0, muestra_out=0, accumulator=0, x0,x1,x2,y1,y2=0, including mid-computation; the aborted sample is discarded.
REQ-024 SHALL start operation at the first rising edge with reset_n=1.

Structure
REQ-025 SHALL place FSM state encodings, selector codes and ANCHO/FRAC defaults in a shared package used also by the coefficient mux.
REQ-026 SHALL have one sub-module, filtro_mac_sat: signed multiply-accumulate with clear, add/sub control and shift-plus-saturate output.
REQ-027 SHALL have no combinational path from Constantes to any output.

Verification
REQ-028 SHALL check impulse with team coefficient mux: x=25'h0002000 then x=0 -> muestra_out 25'h0000003 then 25'h0000012.
REQ-029 SHALL check positive saturation: bench returns Constantes=25'h0FFFFFF for all codes, x=25'h0FFFFFF -> muestra_out=25'h0FFFFFF.
REQ-030 SHALL check negative saturation: same constants, fresh reset, x=25'h1000000 -> muestra_out=25'h1000000.
REQ-031 SHALL check timing: inicio pulse -> selector sequence 011,100,101,001,010 on consecutive cycles, listo high exactly one cycle 7 edges after, ocupado high throughout.
REQ-032 SHALL check inicio held high continuously -> one result per 9 cycles, no extra or lost listo pulses.
REQ-033 SHALL check reset_n pulsed low during MAC step 2 -> outputs zero immediately, no listo; next impulse reproduces REQ-028 values.
